e1_rx_byte_sched: RTL and testbench

Receive-side byte scheduler for the E1 tributary bank. It collects the per-byte valid strobes and bytes from NCH E1 Rx framers, which have already been synchronized into the 19 MHz domain. It buffers one byte per channel and grants the shared write port toward the VC/VT mapping buffer round-robin, one byte per clk19 cycle, with a valid/ready handshake. It flags per-channel overruns and lets the control plane enable or disable individual channels.

---
 rtl/e1_rx_byte_sched.sv | 124 ++++++++++++
 tb/tb_e1_rx_byte_sched.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/e1_rx_byte_sched.sv
// Receive-side byte scheduler: buffers one byte per E1 channel and grants the shared
// write port round-robin, one byte per clk19 cycle, with a valid/ready handshake.
module e1_rx_byte_sched #(
  parameter int unsigned NCH = 21,
  parameter int unsigned CHW = 5
) (
  input  logic             clk19,
  input  logic             rst,
  input  logic [NCH-1:0]   chen,
  input  logic [NCH-1:0]   chvld,
  input  logic [NCH*8-1:0] chdata,
  input  logic [NCH-1:0]   chais,
  input  logic             wrrdy,
  output logic             wren,
  output logic [CHW-1:0]   wrch,
  output logic [7:0]       wrdat,
  output logic             wrais,
  output logic [NCH-1:0]   ovrflg,
  input  logic             ovrclr
);

  logic [NCH-1:0] pv_q;
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] hais_q;
  logic [NCH-1:0] ovrflg_q;
  logic [NCH-1:0] cap;
  logic [NCH-1:0] ovr;
  logic [7:0]     hold_q [NCH];
  logic [CHW-1:0] lastch_q;
  logic [CHW-1:0] sel;
  logic           any;
  logic           out_free;
  logic           grant;

  logic           wren_q;
  logic [CHW-1:0] wrch_q;
  logic [7:0]     wrdat_q;
  logic           wrais_q;

  assign cap      = chvld & ~pv_q & chen;
  assign out_free = ~wren_q | wrrdy;
  assign grant    = out_free & any;

  // Round-robin search starting just after the last granted channel.
  always_comb begin : arb
    logic [CHW:0] idx;
    sel = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 1; k <= int'(NCH); k++) begin
      idx = {1'b0, lastch_q} + (CHW+1)'(k);
      if (idx >= (CHW+1)'(NCH)) begin
        idx = idx - (CHW+1)'(NCH);
      end
      if (!any && pend_q[idx[CHW-1:0]]) begin
        any = 1'b1;
        sel = idx[CHW-1:0];
      end
    end
  end

  // A capture on the channel being granted re-arms pend with the newer byte.
  always_comb begin
    pend_d = pend_q;
    ovr    = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (grant && (sel == CHW'(i))) begin
        pend_d[i] = 1'b0;
      end
      ovr[i] = cap[i] & pend_q[i] & ~(grant && (sel == CHW'(i)));
      if (cap[i]) begin
        pend_d[i] = 1'b1;
      end
      if (!chen[i]) begin
        pend_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk19) begin
    if (rst) begin
      pv_q     <= '0;
      pend_q   <= '0;
      hais_q   <= '0;
      ovrflg_q <= '0;
      lastch_q <= CHW'(NCH - 1);
      wren_q   <= 1'b0;
      wrch_q   <= '0;
      wrdat_q  <= 8'h00;
      wrais_q  <= 1'b0;
      for (int i = 0; i < int'(NCH); i++) begin
        hold_q[i] <= 8'h00;
      end
    end else begin
      pv_q     <= chvld;
      pend_q   <= pend_d;
      ovrflg_q <= (ovrflg_q & ~{NCH{ovrclr}}) | ovr;
      for (int i = 0; i < int'(NCH); i++) begin
        if (cap[i]) begin
          hold_q[i] <= chdata[8*i +: 8];
          hais_q[i] <= chais[i];
        end
      end
      if (out_free) begin
        if (any) begin
          wren_q   <= 1'b1;
          wrch_q   <= sel;
          wrdat_q  <= hold_q[sel];
          wrais_q  <= hais_q[sel];
          lastch_q <= sel;
        end else begin
          wren_q <= 1'b0;
        end
      end
    end
  end

  assign wren   = wren_q;
  assign wrch   = wrch_q;
  assign wrdat  = wrdat_q;
  assign wrais  = wrais_q;
  assign ovrflg = ovrflg_q;

endmodule

// File: tb/tb_e1_rx_byte_sched.sv
// Directed self-checking bench for e1_rx_byte_sched: a per-cycle vector table for the
// single-channel and round-robin cases, plus hand-written multi-cycle sequences.
module tb_e1_rx_byte_sched;

  localparam int unsigned NCH = 21;
  localparam int unsigned CHW = 5;

  logic             clk19 = 1'b0;
  logic             rst;
  logic [NCH-1:0]   chen;
  logic [NCH-1:0]   chvld;
  logic [NCH*8-1:0] chdata;
  logic [NCH-1:0]   chais;
  logic             wrrdy;
  logic             wren;
  logic [CHW-1:0]   wrch;
  logic [7:0]       wrdat;
  logic             wrais;
  logic [NCH-1:0]   ovrflg;
  logic             ovrclr;

  int n_tests = 0;
  int n_fail  = 0;

  e1_rx_byte_sched #(
    .NCH(NCH),
    .CHW(CHW)
  ) dut (
    .clk19 (clk19),
    .rst   (rst),
    .chen  (chen),
    .chvld (chvld),
    .chdata(chdata),
    .chais (chais),
    .wrrdy (wrrdy),
    .wren  (wren),
    .wrch  (wrch),
    .wrdat (wrdat),
    .wrais (wrais),
    .ovrflg(ovrflg),
    .ovrclr(ovrclr)
  );

  always #5 clk19 = ~clk19;

  typedef struct {
    logic           rst;
    logic [NCH-1:0] vld;
    logic           rdy;
    logic           ex_en;
    logic [CHW-1:0] ex_ch;
    logic [7:0]     ex_dat;
  } vec_t;

  vec_t tbl[13];

  task automatic step();
    @(posedge clk19);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_byte(input int ch, input logic [7:0] val);
    chdata[8*ch +: 8] = val;
  endtask

  initial begin
    rst    = 1'b1;
    chen   = '1;
    chvld  = '0;
    chais  = '0;
    wrrdy  = 1'b1;
    ovrclr = 1'b0;
    for (int i = 0; i < int'(NCH); i++) begin
      chdata[8*i +: 8] = 8'(i);
    end
    set_byte(5, 8'hA5);
    set_byte(2, 8'h22);
    set_byte(9, 8'h99);

    // rst, vld, rdy, expected wren, wrch, wrdat (wrch/wrdat checked only when wren=1)
    tbl[0]  = '{1'b0, 21'h000020, 1'b1, 1'b0, 5'd0,  8'h00};
    tbl[1]  = '{1'b0, 21'h000020, 1'b1, 1'b1, 5'd5,  8'hA5};
    tbl[2]  = '{1'b0, 21'h000000, 1'b1, 1'b0, 5'd0,  8'h00};
    tbl[3]  = '{1'b1, 21'h000000, 1'b1, 1'b0, 5'd0,  8'h00};
    tbl[4]  = '{1'b0, 21'h100088, 1'b1, 1'b0, 5'd0,  8'h00};
    tbl[5]  = '{1'b0, 21'h100088, 1'b1, 1'b1, 5'd3,  8'h03};
    tbl[6]  = '{1'b0, 21'h000000, 1'b1, 1'b1, 5'd7,  8'h07};
    tbl[7]  = '{1'b0, 21'h000000, 1'b1, 1'b1, 5'd20, 8'h14};
    tbl[8]  = '{1'b0, 21'h000000, 1'b1, 1'b0, 5'd0,  8'h00};
    tbl[9]  = '{1'b0, 21'h000081, 1'b1, 1'b0, 5'd0,  8'h00};
    tbl[10] = '{1'b0, 21'h000000, 1'b1, 1'b1, 5'd0,  8'h00};
    tbl[11] = '{1'b0, 21'h000000, 1'b1, 1'b1, 5'd7,  8'h07};
    tbl[12] = '{1'b0, 21'h000000, 1'b1, 1'b0, 5'd0,  8'h00};

    step();
    step();
    chk("rst_wren", 32'(wren), 32'h0);
    chk("rst_wrch", 32'(wrch), 32'h0);
    chk("rst_wrdat", 32'(wrdat), 32'h0);
    chk("rst_wrais", 32'(wrais), 32'h0);
    chk("rst_ovrflg", 32'(ovrflg), 32'h0);
    rst = 1'b0;

    for (int r = 0; r < 13; r++) begin
      rst   = tbl[r].rst;
      chvld = tbl[r].vld;
      wrrdy = tbl[r].rdy;
      step();
      chk($sformatf("vec%0d_wren", r), 32'(wren), 32'(tbl[r].ex_en));
      if (tbl[r].ex_en) begin
        chk($sformatf("vec%0d_wrch", r), 32'(wrch), 32'(tbl[r].ex_ch));
        chk($sformatf("vec%0d_wrdat", r), 32'(wrdat), 32'(tbl[r].ex_dat));
      end
      chk($sformatf("vec%0d_ovrflg", r), 32'(ovrflg), 32'h0);
    end
    rst = 1'b0;

    // Backpressure: lastch=7, so channel 9 is presented before channel 2.
    wrrdy = 1'b0;
    chvld = 21'h000204;
    step();
    step();
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp%0d_wren", c), 32'(wren), 32'h1);
      chk($sformatf("bp%0d_wrch", c), 32'(wrch), 32'd9);
      chk($sformatf("bp%0d_wrdat", c), 32'(wrdat), 32'h99);
      if (c < 9) step();
    end
    wrrdy = 1'b1;
    chvld = '0;
    step();
    chk("bp_next_wren", 32'(wren), 32'h1);
    chk("bp_next_wrch", 32'(wrch), 32'd2);
    chk("bp_next_wrdat", 32'(wrdat), 32'h22);
    step();
    chk("bp_idle_wren", 32'(wren), 32'h0);

    // Overrun: channel 1 occupies the stalled output while channel 4 rises twice.
    wrrdy = 1'b0;
    chvld[1] = 1'b1;
    step();
    step();
    chk("ov_block_wrch", 32'(wrch), 32'd1);
    set_byte(4, 8'h11);
    chvld[4] = 1'b1;
    step();
    chk("ov_first_flg", 32'(ovrflg), 32'h0);
    chvld[4] = 1'b0;
    step();
    set_byte(4, 8'h44);
    chvld[4] = 1'b1;
    step();
    chk("ov_set_flg", 32'(ovrflg), 32'h000010);
    chvld = '0;
    step();
    chk("ov_stall_wrch", 32'(wrch), 32'd1);
    wrrdy = 1'b1;
    step();
    chk("ov_xfer_wren", 32'(wren), 32'h1);
    chk("ov_xfer_wrch", 32'(wrch), 32'd4);
    chk("ov_xfer_wrdat", 32'(wrdat), 32'h44);
    step();
    chk("ov_sole_wren", 32'(wren), 32'h0);
    chk("ov_sticky_flg", 32'(ovrflg), 32'h000010);
    ovrclr = 1'b1;
    step();
    ovrclr = 1'b0;
    chk("ov_clr_flg", 32'(ovrflg), 32'h0);

    // Overrun coinciding with ovrclr keeps the flag set.
    wrrdy = 1'b0;
    chvld[1] = 1'b1;
    step();
    step();
    set_byte(4, 8'h11);
    chvld[4] = 1'b1;
    step();
    chvld[4] = 1'b0;
    step();
    chvld[4] = 1'b1;
    ovrclr = 1'b1;
    step();
    ovrclr = 1'b0;
    chk("ov_clrwin_flg", 32'(ovrflg), 32'h000010);
    chvld = '0;
    wrrdy = 1'b1;
    step();
    chk("ov2_xfer_wrch", 32'(wrch), 32'd4);
    chk("ov2_xfer_wrdat", 32'(wrdat), 32'h11);
    step();
    step();
    chk("ov2_idle_wren", 32'(wren), 32'h0);

    // Disabled channel 6 never produces a transfer.
    chen[6] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chvld[6] = c[0];
      step();
      chk($sformatf("dis%0d_wren", c), 32'(wren), 32'h0);
    end
    chvld[6] = 1'b0;
    step();
    chen[6]  = 1'b1;
    chais[6] = 1'b1;
    set_byte(6, 8'hFF);
    chvld[6] = 1'b1;
    step();
    chk("ais_lat_wren", 32'(wren), 32'h0);
    step();
    chk("ais_wren", 32'(wren), 32'h1);
    chk("ais_wrch", 32'(wrch), 32'd6);
    chk("ais_wrdat", 32'(wrdat), 32'hFF);
    chk("ais_wrais", 32'(wrais), 32'h1);
    chvld = '0;
    chais = '0;
    step();
    chk("ais_idle_wren", 32'(wren), 32'h0);

    // Reset mid-burst with five channels pending.
    wrrdy = 1'b0;
    chvld = 21'h007C00;
    step();
    step();
    chk("mb_wren", 32'(wren), 32'h1);
    chk("mb_wrch", 32'(wrch), 32'd10);
    rst = 1'b1;
    step();
    chk("mb_rst_wren", 32'(wren), 32'h0);
    chk("mb_rst_wrch", 32'(wrch), 32'h0);
    chk("mb_rst_wrdat", 32'(wrdat), 32'h0);
    chk("mb_rst_wrais", 32'(wrais), 32'h0);
    chk("mb_rst_ovrflg", 32'(ovrflg), 32'h0);
    chvld = '0;
    rst   = 1'b0;
    wrrdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("mb_stale%0d_wren", c), 32'(wren), 32'h0);
    end
    chvld[12] = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("mb_redet_lat_wren", 32'(wren), 32'h0);
    step();
    chk("mb_redet_wren", 32'(wren), 32'h1);
    chk("mb_redet_wrch", 32'(wrch), 32'd12);
    chk("mb_redet_wrdat", 32'(wrdat), 32'h0C);
    chvld = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
